cram_loader: RTL and testbench
==============================

// Module: cram_loader
// PURPOSE
//  Sequences the configuration scan chain of a fabric tile/array: accepts a
//  bitstream as parallel words over a valid/ready handshake, shifts it serially
//  into the CRAM chain head with config_en asserted, then optionally recirculates
//  the chain once to CRC-check what was captured. Holds logic in reset while
//  loading and releases le_nrst/le_en only after a successful load.
// PARAMETERS
//  WORD_WIDTH  16    width of host bitstream words
//  CHAIN_LEN   1024  total CRAM bits in the chain (head to tail)
//  CNT_W       $clog2(CHAIN_LEN+1)  bit-counter width (derived, not overridden)
// PORTS
//  clk          in   1           CRAM clock; also clocks this block
//  nrst         in   1           async active-low reset
//  start        in   1           pulse: begin a load (ignored unless IDLE/DONE/ERROR)
//  verify_en    in   1           sampled with start: 1 = run CRC recirculation pass
//  word_data    in   WORD_WIDTH  bitstream word, bit 0 shifted first
//  word_valid   in   1           word_data valid
//  word_ready   out  1           loader accepts word this cycle
//  cfg_data_out out  1           serial bit to chain head (config_data_in)
//  cfg_en       out  1           chain shift enable (config_en)
//  cfg_data_in  in   1           chain tail (config_data_out)
//  le_nrst      out  1           fabric logic reset, active-low
//  le_en        out  1           fabric logic enable
//  busy         out  1           high in FETCH/SHIFT/VERIFY
//  done         out  1           level, high in DONE
//  error        out  1           level, high in ERROR (CRC mismatch)
// BEHAVIOUR
//  - Reset: state IDLE; word_ready=0, cfg_en=0, cfg_data_out=0, le_nrst=0,
//    le_en=0, busy=0, done=0, error=0; counters and CRCs cleared.
//  - IDLE: outputs as reset. start -> FETCH; latch verify_en; bit_cnt=0, crc_tx=crc_rx=16'hFFFF.
//  - FETCH: word_ready=1, cfg_en=0. word_valid&&word_ready -> load shift reg,
//    bits_in_word = min(WORD_WIDTH, CHAIN_LEN-bit_cnt); -> SHIFT next cycle.
//  - SHIFT: cfg_en=1, cfg_data_out=sreg[0] each cycle; sreg>>=1; bit_cnt++;
//    crc_tx updated with the bit sent (serial CRC-16-CCITT, poly 16'h1021, MSB feedback).
//    Word exhausted: bit_cnt<CHAIN_LEN -> FETCH; bit_cnt==CHAIN_LEN -> VERIFY
//    if verify latched, else DONE. Final partial word: upper unused bits discarded.
//  - Each word costs 1 FETCH cycle + bits_in_word SHIFT cycles minimum; host
//    stalls (word_valid=0) hold FETCH with cfg_en=0, chain contents frozen.
//  - VERIFY: cfg_en=1, cfg_data_out=cfg_data_in (recirculate) for exactly
//    CHAIN_LEN cycles; crc_rx updated with cfg_data_in. Chain ends identical to
//    loaded image. After last bit: crc_rx==crc_tx -> DONE else ERROR.
//  - DONE: cfg_en=0, le_nrst=1, le_en=1, done=1. start -> FETCH (reload; le_nrst
//    and le_en drop in the same cycle state leaves DONE).
//  - ERROR: error=1, le_nrst=0, le_en=0, cfg_en=0. start -> FETCH (retry).
//  - start while busy: ignored. word_valid outside FETCH: not consumed.
//  - Async reset mid-load: immediate return to reset values; chain contents
//    undefined, fabric held in reset until a new full load completes.
//  - cfg_en is registered and aligned with cfg_data_out (same-cycle valid).
// STRUCTURE
//  - Package cram_pkg: typedef enum logic [2:0] {IDLE,FETCH,SHIFT,VERIFY,DONE,
//    ERROR} cram_ld_state_t; localparam CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
//  - One sub-module: cram_crc16_serial (bit_in, en, clr -> crc[15:0]),
//    instantiated twice (tx, rx).
// TESTING  (bench: CHAIN_LEN=40, WORD_WIDTH=16, behavioural 40-bit shift chain)
//  1 start, verify_en=0, words 16'hA5A5,16'h0FF0,16'h00C3 back-to-back -> 40
//    cfg_en cycles, chain holds 40'hC3_0FF0_A5A5, done=1, le_nrst=1 after 43 SHIFT+FETCH cycles.
//  2 same with verify_en=1 -> 40 extra recirculate cycles, chain unchanged, done=1, error=0.
//  3 verify_en=1, bench flips chain bit 7 mid-VERIFY -> error=1, le_nrst=0, done=0.
//  4 word_valid deasserted 5 cycles between words -> cfg_en=0 during stall,
//    final chain identical to test 1.
//  5 nrst asserted during SHIFT of word 2 -> all outputs at reset values same
//    cycle; new start + full load -> done=1, correct image.
//  6 start pulsed while busy and from DONE -> ignored while busy; from DONE le_nrst
//    drops next cycle and reload completes with new image.

Source files
------------

// File: rtl/cram_pkg.sv
// ---------------------------------------------------------------------------
// cram_pkg
//   Shared types and constants for the CRAM configuration loader.
//   - cram_ld_state_t : loader FSM state encoding
//   - CRC_POLY/CRC_INIT: CRC-16-CCITT parameters used on the load and
//                        verify streams
//   - crc16_step      : one serial CRC step (MSB feedback), shared by the
//                       CRC sub-module and the final CRC compare in the top
// ---------------------------------------------------------------------------
package cram_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      SHIFT  = 3'd2,
      VERIFY = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } cram_ld_state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Serial CRC-16-CCITT: feedback is the register MSB xor the incoming bit.
   function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                              input logic        bit_in);
      logic fb;
      fb = crc[15] ^ bit_in;
      return fb ? ({crc[14:0], 1'b0} ^ CRC_POLY) : {crc[14:0], 1'b0};
   endfunction

endpackage

// File: rtl/cram_crc16_serial.sv
// ---------------------------------------------------------------------------
// cram_crc16_serial
//   Bit-serial CRC-16-CCITT accumulator.
//   Ports:
//     clk    in   clock
//     nrst   in   async active-low reset (crc returns to CRC_INIT)
//     clr    in   synchronous clear to CRC_INIT (has priority over en)
//     en     in   fold bit_in into the CRC this cycle
//     bit_in in   serial data bit
//     crc    out  current CRC register value
// ---------------------------------------------------------------------------
module cram_crc16_serial
   import cram_pkg::*;
(
   input  logic        clk,
   input  logic        nrst,
   input  logic        clr,
   input  logic        en,
   input  logic        bit_in,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr) begin
         crc_d = CRC_INIT;
      end else if (en) begin
         crc_d = crc16_step(crc_q, bit_in);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/cram_loader.sv
// ---------------------------------------------------------------------------
// cram_loader
//   Loads a fabric CRAM scan chain from a stream of host words, optionally
//   recirculates the chain once to CRC-check what was captured, and releases
//   the fabric logic from reset only after a successful load.
//
//   Host handshake: a word is transferred on every rising clk edge where
//   word_valid && word_ready are both high; word_ready is only high in FETCH,
//   so word_valid outside FETCH is never consumed.
//
//   Ports:
//     clk          in   CRAM clock, also clocks this block
//     nrst         in   async active-low reset
//     start        in   pulse: begin a load (only from IDLE/DONE/ERROR)
//     verify_en    in   sampled with start: run CRC recirculation pass
//     word_data    in   bitstream word, bit 0 shifted first
//     word_valid   in   word_data valid
//     word_ready   out  loader accepts a word this cycle
//     cfg_data_out out  serial bit to chain head
//     cfg_en       out  chain shift enable, aligned with cfg_data_out
//     cfg_data_in  in   chain tail
//     le_nrst      out  fabric logic reset, active-low
//     le_en        out  fabric logic enable
//     busy         out  high in FETCH/SHIFT/VERIFY
//     done         out  high in DONE
//     error        out  high in ERROR (CRC mismatch)
//     dbg_state    out  current FSM state
// ---------------------------------------------------------------------------
module cram_loader
   import cram_pkg::*;
#(
   parameter int WORD_WIDTH = 16,
   parameter int CHAIN_LEN  = 1024,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1),
   localparam int BL_W      = $clog2(WORD_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  verify_en,
   input  logic [WORD_WIDTH-1:0] word_data,
   input  logic                  word_valid,
   output logic                  word_ready,
   output logic                  cfg_data_out,
   output logic                  cfg_en,
   input  logic                  cfg_data_in,
   output logic                  le_nrst,
   output logic                  le_en,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output cram_ld_state_t        dbg_state
);

   cram_ld_state_t        state_q, state_d;
   logic                  verify_q, verify_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [BL_W-1:0]       bits_left_q, bits_left_d;
   logic [WORD_WIDTH-1:0] sreg_q, sreg_d;

   logic word_ready_q, word_ready_d;
   logic cfg_data_out_q, cfg_data_out_d;
   logic cfg_en_q, cfg_en_d;
   logic le_nrst_q, le_nrst_d;
   logic le_en_q, le_en_d;
   logic busy_q, busy_d;
   logic done_q, done_d;
   logic error_q, error_d;

   logic        crc_clr;
   logic        tx_en;
   logic        rx_en;
   logic [15:0] crc_tx;
   logic [15:0] crc_rx;
   int          remaining;

   always_comb begin
      state_d        = state_q;
      verify_d       = verify_q;
      bit_cnt_d      = bit_cnt_q;
      bits_left_d    = bits_left_q;
      sreg_d         = sreg_q;
      cfg_data_out_d = 1'b0;
      crc_clr        = 1'b0;
      tx_en          = 1'b0;
      rx_en          = 1'b0;
      remaining      = CHAIN_LEN - int'(bit_cnt_q);

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d   = FETCH;
               verify_d  = verify_en;
               bit_cnt_d = '0;
               crc_clr   = 1'b1;
            end
         end
         FETCH: begin
            // word_ready_q is high for the whole FETCH state.
            if (word_valid) begin
               // Bit 0 goes out on the first SHIFT cycle; the rest queue in sreg.
               cfg_data_out_d = word_data[0];
               sreg_d         = word_data >> 1;
               bits_left_d    = (remaining < WORD_WIDTH) ? BL_W'(remaining)
                                                         : BL_W'(WORD_WIDTH);
               state_d        = SHIFT;
            end
         end
         SHIFT: begin
            // The chain captures cfg_data_out_q on this edge.
            tx_en       = 1'b1;
            bit_cnt_d   = bit_cnt_q + 1'b1;
            bits_left_d = bits_left_q - 1'b1;
            if (bits_left_q == BL_W'(1)) begin
               if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                  if (verify_q) begin
                     state_d   = VERIFY;
                     bit_cnt_d = '0;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  state_d = FETCH;
               end
            end else begin
               cfg_data_out_d = sreg_q[0];
               sreg_d         = sreg_q >> 1;
            end
         end
         VERIFY: begin
            rx_en     = 1'b1;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
               // Include the bit captured on this final edge in the compare.
               state_d = (crc16_step(crc_rx, cfg_data_in) == crc_tx) ? DONE : ERROR;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they are registered
      // and change on the same edge as the state itself.
      word_ready_d = (state_d == FETCH);
      cfg_en_d     = (state_d == SHIFT) || (state_d == VERIFY);
      le_nrst_d    = (state_d == DONE);
      le_en_d      = (state_d == DONE);
      busy_d       = (state_d == FETCH) || (state_d == SHIFT) || (state_d == VERIFY);
      done_d       = (state_d == DONE);
      error_d      = (state_d == ERROR);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q        <= IDLE;
         verify_q       <= 1'b0;
         bit_cnt_q      <= '0;
         bits_left_q    <= '0;
         sreg_q         <= '0;
         word_ready_q   <= 1'b0;
         cfg_data_out_q <= 1'b0;
         cfg_en_q       <= 1'b0;
         le_nrst_q      <= 1'b0;
         le_en_q        <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         verify_q       <= verify_d;
         bit_cnt_q      <= bit_cnt_d;
         bits_left_q    <= bits_left_d;
         sreg_q         <= sreg_d;
         word_ready_q   <= word_ready_d;
         cfg_data_out_q <= cfg_data_out_d;
         cfg_en_q       <= cfg_en_d;
         le_nrst_q      <= le_nrst_d;
         le_en_q        <= le_en_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         error_q        <= error_d;
      end
   end

   cram_crc16_serial u_crc_tx (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (crc_clr),
      .en     (tx_en),
      .bit_in (cfg_data_out_q),
      .crc    (crc_tx)
   );

   cram_crc16_serial u_crc_rx (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (crc_clr),
      .en     (rx_en),
      .bit_in (cfg_data_in),
      .crc    (crc_rx)
   );

   // Recirculation must be a straight wire from tail to head: a flop in the
   // loop would lengthen the ring to CHAIN_LEN+1 and scramble the image.
   assign cfg_data_out = (state_q == VERIFY) ? cfg_data_in : cfg_data_out_q;
   assign word_ready   = word_ready_q;
   assign cfg_en       = cfg_en_q;
   assign le_nrst      = le_nrst_q;
   assign le_en        = le_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_cram_loader.sv
module tb_cram_loader;
   import cram_pkg::*;

   localparam int CL = 40;
   localparam int WW = 16;
   localparam logic [CL-1:0] FLIP_MASK = 40'h00_0000_0080;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   logic          start = 1'b0;
   logic          verify_en = 1'b0;
   logic [WW-1:0] word_data = '0;
   logic          word_valid = 1'b0;
   logic          word_ready, cfg_data_out, cfg_en, cfg_data_in;
   logic          le_nrst, le_en, busy, done, error;
   cram_ld_state_t dbg_state;

   cram_loader #(.WORD_WIDTH(WW), .CHAIN_LEN(CL)) dut (
      .clk(clk), .nrst(nrst), .start(start), .verify_en(verify_en),
      .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
      .cfg_data_out(cfg_data_out), .cfg_en(cfg_en), .cfg_data_in(cfg_data_in),
      .le_nrst(le_nrst), .le_en(le_en), .busy(busy), .done(done), .error(error),
      .dbg_state(dbg_state)
   );

   // ---------------- behavioural CRAM chain ----------------
   logic [CL-1:0] chain = '0;
   logic          flip_req = 1'b0;
   always @(posedge clk)
      chain <= (cfg_en ? {cfg_data_out, chain[CL-1:1]} : chain) ^ (flip_req ? FLIP_MASK : '0);
   assign cfg_data_in = chain[0];

   // Free-running activity counters; the bench takes snapshots around a load.
   int busy_total = 0;
   int cfg_en_total = 0;
   always @(negedge clk) begin
      if (busy) busy_total <= busy_total + 1;
      if (cfg_en) cfg_en_total <= cfg_en_total + 1;
   end

   logic [7:0] status;
   assign status = {word_ready, cfg_en, cfg_data_out, le_nrst, le_en, busy, done, error};

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass = 0;
   int busy_snap, cfg_snap;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- driver tasks (all enter and leave at a negedge) ----------------
   task automatic do_reset();
      nrst = 1'b0; start = 1'b0; word_valid = 1'b0; flip_req = 1'b0;
      repeat (3) @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start(input logic v);
      busy_snap = busy_total;
      cfg_snap  = cfg_en_total;
      start = 1'b1; verify_en = v;
      @(negedge clk);
      start = 1'b0; verify_en = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!word_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("wait_ready_timeout", 64'(n), 64'(0));
   endtask

   task automatic send_word(input logic [WW-1:0] w);
      word_valid = 1'b1; word_data = w;
      wait_ready();
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || error) && n < 500) begin @(negedge clk); n++; end
      if (n >= 500) check("wait_end_timeout", 64'(n), 64'(0));
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      string      name;
      logic       verify;
      int         stall;
      logic       flip;
      logic [7:0] exp_status;
      int         exp_busy;
      int         exp_cfg_en;
      logic       chk_chain;
   } vec_t;

   vec_t          vecs[4];
   logic [WW-1:0] words_a[3];
   logic [WW-1:0] words_b[3];
   localparam logic [CL-1:0] IMG_A = 40'hC3_0FF0_A5A5;
   localparam logic [CL-1:0] IMG_B = 40'h9A_5678_1234;

   initial begin
      // status bits: {word_ready,cfg_en,cfg_data_out,le_nrst,le_en,busy,done,error}
      vecs[0] = '{"plain",  1'b0, 0, 1'b0, 8'h1A, 43, 40, 1'b1};
      vecs[1] = '{"verify", 1'b1, 0, 1'b0, 8'h1A, 83, 80, 1'b1};
      vecs[2] = '{"flip",   1'b1, 0, 1'b1, 8'h01, 83, 80, 1'b0};
      vecs[3] = '{"stall",  1'b0, 5, 1'b0, 8'h1A, 53, 40, 1'b1};
      words_a = '{16'hA5A5, 16'h0FF0, 16'h00C3};
      words_b = '{16'h1234, 16'h5678, 16'h009A};

      do_reset();
      check("reset_status", 64'(status), 64'(0));

      for (int t = 0; t < 4; t++) begin
         pulse_start(vecs[t].verify);
         for (int w = 0; w < 3; w++) begin
            if (w > 0 && vecs[t].stall > 0) begin
               wait_ready();
               for (int s = 0; s < vecs[t].stall; s++) begin
                  @(negedge clk);
                  check({vecs[t].name, "_stall_cfg_en"}, 64'(cfg_en), 64'(0));
               end
            end
            send_word(words_a[w]);
         end
         if (vecs[t].flip) begin
            repeat (20) @(negedge clk);
            flip_req = 1'b1;
            @(negedge clk);
            flip_req = 1'b0;
         end
         wait_end();
         check({vecs[t].name, "_status"}, 64'(status), 64'(vecs[t].exp_status));
         check({vecs[t].name, "_busy_cycles"}, 64'(busy_total - busy_snap), 64'(vecs[t].exp_busy));
         check({vecs[t].name, "_cfg_en_cycles"}, 64'(cfg_en_total - cfg_snap), 64'(vecs[t].exp_cfg_en));
         if (vecs[t].chk_chain) check({vecs[t].name, "_chain"}, 64'(chain), 64'(IMG_A));
      end

      // Async reset during SHIFT of word 2, then a clean full load.
      pulse_start(1'b0);
      send_word(words_a[0]);
      send_word(words_a[1]);
      repeat (3) @(negedge clk);
      nrst = 1'b0;
      #1;
      check("midload_reset_status", 64'(status), 64'(0));
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chain = '0;
      pulse_start(1'b0);
      for (int w = 0; w < 3; w++) send_word(words_a[w]);
      wait_end();
      check("after_reset_status", 64'(status), 64'(8'h1A));
      check("after_reset_chain", 64'(chain), 64'(IMG_A));

      // start while busy is ignored (no restart, verify not latched).
      pulse_start(1'b0);
      send_word(words_a[0]);
      start = 1'b1; verify_en = 1'b1;
      @(negedge clk);
      start = 1'b0; verify_en = 1'b0;
      send_word(words_a[1]);
      send_word(words_a[2]);
      wait_end();
      check("busy_start_status", 64'(status), 64'(8'h1A));
      check("busy_start_cycles", 64'(busy_total - busy_snap), 64'(43));
      check("busy_start_cfg_en", 64'(cfg_en_total - cfg_snap), 64'(40));

      // start from DONE: fabric drops on the very next edge, reload new image.
      start = 1'b1;
      @(posedge clk);
      #1;
      check("reload_le_drop", 64'({le_nrst, le_en, done, busy}), 64'(4'b0001));
      @(negedge clk);
      start = 1'b0;
      for (int w = 0; w < 3; w++) send_word(words_b[w]);
      wait_end();
      check("reload_status", 64'(status), 64'(8'h1A));
      check("reload_chain", 64'(chain), 64'(IMG_B));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
